// File: rtl/eda_push_queue.sv
// eda_push_queue: serialises neighbour push pulses into linear addresses queued in a show-ahead FIFO
module eda_push_queue #(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(M*N),
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          new_pixel,
  input  logic [ADDR_WIDTH-1:0]         center_addr,
  input  logic [WINDOW_WIDTH-2:0]       push_positions,
  output logic [WINDOW_WIDTH-2:0]       iterated_idx,
  input  logic                          pop_req,
  output logic                          pop_valid,
  output logic [ADDR_WIDTH-1:0]         pop_addr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          busy
);
  localparam int NB = WINDOW_WIDTH - 1;
  localparam int SW = $clog2(NB);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WD = 3;
  logic [ADDR_WIDTH-1:0] center_reg;
  logic [ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [NB-1:0]         pending, req, rest;
  logic [SW-1:0]         sel;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic [ADDR_WIDTH-1:0] nb_addr;
  logic                  do_write, do_pop;
  int                    p, row, col;
  // pick the lowest requested neighbour and form its address; the centre slot is skipped in the mask
  always_comb begin
    req = pending | push_positions;
    sel = '0;
    for (int i = NB - 1; i >= 0; i--) if (req[i]) sel = SW'(i);
    p = int'(sel) + ((int'(sel) >= NB / 2) ? 1 : 0);
    row = p / WD;
    col = p % WD;
    nb_addr = center_reg + ADDR_WIDTH'(row * N + col) - ADDR_WIDTH'(N + 1);
    rest = req & ~(NB'(1) << sel);
    do_write = !new_pixel && (req != '0) && !fifo_full;
    do_pop = pop_req && pop_valid;
  end
  // centre, pending mask, iterated mask and FIFO pointers; a new centre drops stale pushes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      center_reg   <= '0;
      pending      <= '0;
      iterated_idx <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      if (new_pixel) begin
        center_reg   <= center_addr;
        pending      <= '0;
        iterated_idx <= '0;
      end else if (do_write) begin
        pending           <= rest;
        iterated_idx[sel] <= 1'b1;
      end else begin
        pending <= req;
      end
      wr_ptr <= wr_ptr + PW'(do_write);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count  <= count + (PW+1)'(do_write) - (PW+1)'(do_pop);
    end
  end
  // queue storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= nb_addr;
  end
  assign pop_valid  = count != '0;
  assign pop_addr   = mem[rd_ptr];
  assign fifo_count = count;
  assign fifo_full  = count == (PW+1)'(FIFO_DEPTH);
  assign busy       = (pending != '0) || (push_positions != '0);
endmodule

// File: doc/eda_push_queue.md
Name: eda_push_queue

Overview:
- Consumer end of the compare stage's neighbour-push interface in the regional-maxima flood step.
- Takes the one-hot-per-neighbour push pulses for the current centre pixel and serialises each set bit into a linear neighbour address.
- Writes those addresses into an internal show-ahead FIFO that the traversal controller pops.
- Returns the per-neighbour "already queued" mask (iterated_idx) to the compare stage, closing the loop.

Parameters:
- M, 16, image rows
- N, 16, image columns (row stride of linear address)
- WINDOW_WIDTH, 9, 3x3 window size; neighbour mask width is WINDOW_WIDTH-1
- ADDR_WIDTH, $clog2(M*N), linear pixel address width
- FIFO_DEPTH, 16, queue entries (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- new_pixel  in  1  new centre pixel loaded this cycle
- center_addr  in  ADDR_WIDTH  centre linear address, sampled when new_pixel=1
- push_positions  in  WINDOW_WIDTH-1  neighbour push pulses (bit k = window pos k for k<4, k+1 for k>=4)
- iterated_idx  out  WINDOW_WIDTH-1  neighbours already written to FIFO for current centre
- pop_req  in  1  consumer takes head entry
- pop_valid  out  1  FIFO not empty
- pop_addr  out  ADDR_WIDTH  head entry (show-ahead)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- fifo_full  out  1  count == FIFO_DEPTH
- busy  out  1  pending neighbour bits not yet queued

Behaviour:
- Reset (async, reset=1): iterated_idx=0, pending=0, centre reg=0, FIFO pointers/count=0.
  - Outputs after reset: pop_valid=0, fifo_count=0, fifo_full=0, busy=0. pop_addr content is don't-care while pop_valid=0.
  - Reset mid-operation discards all queued and pending entries.
- Window position p (0..8, row-major, 4 = centre) maps to r=p/3-1, c=p%3-1.
  - Neighbour address = centre_reg + r*N + c, computed modulo 2^ADDR_WIDTH.
  - No image-edge check is performed; upstream validity masking is relied on.
- Effective request: req = pending_reg | push_positions.
- Each cycle with req!=0 and fifo_full=0:
  - Select the lowest set bit k.
  - Write its address at the write pointer.
  - Clear bit k from pending; set iterated_idx[k] at the clock edge.
  - Remaining bits are held in pending_reg.
- Throughput: at most one FIFO write per cycle. A mask with n bits set drains in n cycles when not blocked.
- Latency: push_positions bit at cycle t (lowest, FIFO not full) → entry written at end of t → pop_valid=1 and pop_addr valid in cycle t+1. iterated_idx[k] is also visible in t+1.
- fifo_full=1: no write; pending holds all bits; busy stays 1. Writing resumes the cycle after space frees.
- There is no same-cycle pop-to-push bypass when full.
- Pop: pop_req with pop_valid=1 advances the read pointer; pop_req with pop_valid=0 is ignored.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- new_pixel=1:
  - Captures center_addr; clears iterated_idx and pending_reg.
  - push_positions in the same cycle is discarded, since it belongs to the previous centre.
  - FIFO contents are unaffected.
- Bits already set in iterated_idx that reappear in push_positions are re-queued. Dedup is the compare stage's job via iterated_idx.
- busy = (pending_reg != 0) | (push_positions != 0).

Test Plan:
- Reset, then new_pixel with center_addr=0x22 (N=16); push_positions=8'b1000_0001 for one cycle → FIFO writes 0x11 (cycle t) then 0x33 (t+1); iterated_idx goes 0x01 then 0x81; busy deasserts at t+2.
- Full mask 0xFF at centre 0x22 with no pops → pop order 0x11,0x12,0x13,0x21,0x23,0x31,0x32,0x33; fifo_count=8 after 8 cycles.
- FIFO_DEPTH=16 pre-filled with 15 entries, push 0x03 → one write, fifo_full=1, busy=1 holding bit1. One pop → second entry written the next cycle, count returns to 16.
- Pop and write in the same cycle at count=5 → count stays 5; head/tail wrap verified across 40 pushes/pops with addresses matching a scoreboard.
- new_pixel coincident with push_positions=0x10 and pending=0x04 → nothing written; iterated_idx=0, busy=0; center_addr updated; existing FIFO entries still popped intact.
- Assert reset while 3 entries queued and pending≠0 → pop_valid=0, fifo_count=0, iterated_idx=0 immediately (async).
